// File: rtl/mem_port_arbiter_pack.sv
// mem_port_arbiter_pack: round-robin owner arbitration of one memory port with burst pack reads
// assembled into a wide word in normal or reversed order.
module mem_port_arbiter_pack #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int PACK   = 5,
    parameter int RD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           req,
    output logic [NUM_CH-1:0]           grant,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]    ch_wdata,
    input  logic [NUM_CH-1:0]           ch_we,
    input  logic [NUM_CH-1:0]           pack_start,
    input  logic                        pack_rev,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [PACK*DATA_W-1:0]      pack_data,
    output logic                        pack_valid,
    output logic [$clog2(NUM_CH)-1:0]   pack_ch
);
    localparam int CW = $clog2(NUM_CH);
    localparam int NW = $clog2(PACK + RD_LAT + 1);
    localparam logic [NW-1:0] LAUNCH = NW'(PACK);
    localparam logic [NW-1:0] LAT    = NW'(RD_LAT);
    localparam logic [NW-1:0] LAST   = NW'(PACK + RD_LAT - 1);
    localparam logic [NW-1:0] TOP    = NW'(PACK - 1);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_PACK} state_t;

    state_t                 state_q, state_d;
    logic [NUM_CH-1:0]      grant_q, grant_d;
    logic [CW-1:0]          ptr_q, ptr_d, owner_q, owner_d, pack_ch_q, pack_ch_d, sel;
    logic                   found;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d, base_q, base_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic                   mem_we_q, mem_we_d, rev_q, rev_d, pack_valid_q, pack_valid_d;
    logic [PACK*DATA_W-1:0] buf_q, buf_d, pack_data_q, pack_data_d;
    logic [NW-1:0]          cyc_q, cyc_d, word, slot;

    // First requester at or after the round-robin pointer
    always_comb begin
        int j;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && req[j]) begin
                found = 1'b1;
                sel   = CW'(j);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        base_d       = base_q;
        rev_d        = rev_q;
        cyc_d        = cyc_q;
        buf_d        = buf_q;
        pack_data_d  = pack_data_q;
        pack_ch_d    = pack_ch_q;
        pack_valid_d = 1'b0;
        word         = cyc_q - LAT;
        slot         = rev_q ? TOP - word : word;
        case (state_q)
            S_IDLE: begin
                mem_we_d = 1'b0;
                if (found) begin
                    state_d = S_OWN;
                    owner_d = sel;
                    grant_d = NUM_CH'(1) << sel;
                    ptr_d   = (sel == CW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
                end
            end
            S_OWN: begin
                if (!req[owner_q]) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    mem_we_d = 1'b0;
                end else if (pack_start[owner_q]) begin
                    // This edge already launches word 0
                    state_d    = S_PACK;
                    base_d     = ch_addr[owner_q*ADDR_W +: ADDR_W];
                    rev_d      = pack_rev;
                    mem_addr_d = ch_addr[owner_q*ADDR_W +: ADDR_W];
                    mem_we_d   = 1'b0;
                    cyc_d      = NW'(1);
                end else begin
                    mem_addr_d  = ch_addr[owner_q*ADDR_W +: ADDR_W];
                    mem_wdata_d = ch_wdata[owner_q*DATA_W +: DATA_W];
                    mem_we_d    = ch_we[owner_q];
                end
            end
            S_PACK: begin
                mem_we_d = 1'b0;
                cyc_d    = cyc_q + 1'b1;
                if (cyc_q < LAUNCH) mem_addr_d = base_q + ADDR_W'(cyc_q);
                if (cyc_q >= LAT) buf_d[slot*DATA_W +: DATA_W] = mem_rdata;
                if (cyc_q == LAST) begin
                    pack_data_d  = buf_d;
                    pack_ch_d    = owner_q;
                    pack_valid_d = 1'b1;
                    state_d      = req[owner_q] ? S_OWN : S_IDLE;
                    grant_d      = req[owner_q] ? grant_q : '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            ptr_q        <= '0;
            owner_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            base_q       <= '0;
            rev_q        <= 1'b0;
            cyc_q        <= '0;
            buf_q        <= '0;
            pack_data_q  <= '0;
            pack_ch_q    <= '0;
            pack_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            base_q       <= base_d;
            rev_q        <= rev_d;
            cyc_q        <= cyc_d;
            buf_q        <= buf_d;
            pack_data_q  <= pack_data_d;
            pack_ch_q    <= pack_ch_d;
            pack_valid_q <= pack_valid_d;
        end
    end

    assign grant      = grant_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign pack_data  = pack_data_q;
    assign pack_valid = pack_valid_q;
    assign pack_ch    = pack_ch_q;
endmodule
